pc_sequencer: RTL and testbench

- Owns the architectural program counter and sequences fetch redirection for the 5-stage pipeline.
- Takes resolved branch, stall and finish events from the EX/MEM/WB stages.
- Produces the current and previous PC, a pipeline flush strobe and a halt indication.
- Replaces free-running PC update with a clocked, reset-controlled state machine.

---
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer: owns the fetch PC, drives flush after taken branches and halts on finish.
// Optional feature: define PC_ALIGN_CHECK_EN to halt on misaligned branch targets (adds misalign).
`timescale 1ns / 1ps

module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             stall,
    input  logic             branch,
    input  logic [31:0]      branch_target,
    input  logic             finish,
    output logic [31:0]      pc,
    output logic [31:0]      prev_pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             halted,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misalign,
`endif
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StHalt  = 2'd3;

    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      prev_pc_q, prev_pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             flush_q, flush_d;
    logic             halted_q, halted_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             misalign_q, misalign_d;
    logic             bad_target;

`ifdef PC_ALIGN_CHECK_EN
    assign bad_target = (branch_target[1:0] != 2'b00);
`else
    assign bad_target = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        prev_pc_d     = prev_pc_q;
        pc_valid_d    = pc_valid_q;
        flush_d       = flush_q;
        halted_d      = halted_q;
        flush_cnt_d   = flush_cnt_q;
        misalign_d    = misalign_q;
        cycle_count_d = cycle_count_q;

        // Counter runs in every state except HALT and sticks at all-ones.
        if (state_q != StHalt && cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end

        case (state_q)
            StBoot: begin
                state_d    = StRun;
                pc_valid_d = 1'b1;
            end
            StRun: begin
                if (finish) begin
                    state_d    = StHalt;
                    halted_d   = 1'b1;
                    pc_valid_d = 1'b0;
                end else if (branch && bad_target) begin
                    state_d    = StHalt;
                    halted_d   = 1'b1;
                    misalign_d = 1'b1;
                    pc_valid_d = 1'b0;
                end else if (branch) begin
                    state_d     = StFlush;
                    prev_pc_d   = pc_q;
                    pc_d        = branch_target;
                    flush_d     = 1'b1;
                    pc_valid_d  = 1'b0;
                    flush_cnt_d = FlushInit;
                end else if (!stall) begin
                    prev_pc_d = pc_q;
                    pc_d      = pc_q + 32'(PC_STEP);
                end
            end
            StFlush: begin
                if (finish) begin
                    state_d     = StHalt;
                    halted_d    = 1'b1;
                    flush_d     = 1'b0;
                    flush_cnt_d = 4'd0;
                end else if (flush_cnt_q == 4'd0) begin
                    state_d    = StRun;
                    flush_d    = 1'b0;
                    pc_valid_d = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            prev_pc_q     <= RESET_PC;
            pc_valid_q    <= 1'b0;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
            flush_cnt_q   <= 4'd0;
            misalign_q    <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            prev_pc_q     <= prev_pc_d;
            pc_valid_q    <= pc_valid_d;
            flush_q       <= flush_d;
            halted_q      <= halted_d;
            flush_cnt_q   <= flush_cnt_d;
            misalign_q    <= misalign_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign pc          = pc_q;
    assign prev_pc     = prev_pc_q;
    assign pc_valid    = pc_valid_q;
    assign flush       = flush_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_count_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a cycle-level behavioural model.
`timescale 1ns / 1ps

module tb_pc_sequencer;

    localparam int unsigned FlushCycles = 2;

    logic        CLK;
    logic        RST_N;
    logic        stall;
    logic        branch;
    logic [31:0] branch_target;
    logic        finish;
    logic [31:0] pc;
    logic [31:0] prev_pc;
    logic        pc_valid;
    logic        flush;
    logic        halted;
    logic [31:0] cycle_count;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .PC_STEP     (4),
        .FLUSH_CYCLES(FlushCycles),
        .CNT_W       (32)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .stall        (stall),
        .branch       (branch),
        .branch_target(branch_target),
        .finish       (finish),
        .pc           (pc),
        .prev_pc      (prev_pc),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .halted       (halted),
`ifdef PC_ALIGN_CHECK_EN
        .misalign     (misalign),
`endif
        .cycle_count  (cycle_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain architectural view of the sequencer.
    logic [31:0] m_pc, m_prev, m_cc;
    logic        m_valid, m_halted, m_boot, m_mis;
    int          m_flush_left;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_prev = 32'h0; m_cc = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1; m_mis = 1'b0;
        m_flush_left = 0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [31:0] t, input logic f);
        if (m_halted) return;
        if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
        if (m_boot) begin
            m_boot  = 1'b0;
            m_valid = 1'b1;
        end else if (m_flush_left > 0) begin
            if (f) begin
                m_halted = 1'b1; m_flush_left = 0; m_valid = 1'b0;
            end else begin
                m_flush_left--;
                if (m_flush_left == 0) m_valid = 1'b1;
            end
        end else if (f) begin
            m_halted = 1'b1; m_valid = 1'b0;
        end else if (b) begin
`ifdef PC_ALIGN_CHECK_EN
            if (t % 4 != 0) begin
                m_halted = 1'b1; m_mis = 1'b1; m_valid = 1'b0;
                return;
            end
`endif
            m_prev = m_pc; m_pc = t; m_flush_left = FlushCycles; m_valid = 1'b0;
        end else if (!s) begin
            m_prev = m_pc; m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".pc"},       pc,                    m_pc);
        check_eq({tag, ".prev_pc"},  prev_pc,               m_prev);
        check_eq({tag, ".pc_valid"}, {31'b0, pc_valid},     {31'b0, m_valid});
        check_eq({tag, ".flush"},    {31'b0, flush},        {31'b0, m_flush_left > 0});
        check_eq({tag, ".halted"},   {31'b0, halted},       {31'b0, m_halted});
        check_eq({tag, ".cycles"},   cycle_count,           m_cc);
`ifdef PC_ALIGN_CHECK_EN
        check_eq({tag, ".misalign"}, {31'b0, misalign},     {31'b0, m_mis});
`endif
    endtask

    // Called at a falling edge: apply inputs, clock once, compare at next falling edge.
    task automatic tick(input string tag, input logic s, input logic b, input logic [31:0] t,
                        input logic f);
        stall = s; branch = b; branch_target = t; finish = f;
        @(posedge CLK);
        model_step(s, b, t, f);
        @(negedge CLK);
        compare_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        RST_N = 1'b0;
        stall = 1'b0; branch = 1'b0; branch_target = 32'h0; finish = 1'b0;
        model_reset();
        #1;
        compare_all({tag, ".async"});
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        compare_all({tag, ".rel"});
    endtask

    logic [31:0] frozen_cc;

    initial begin
        RST_N = 1'b1;
        stall = 1'b0; branch = 1'b0; branch_target = 32'h0; finish = 1'b0;
        model_reset();
        @(negedge CLK);
        do_reset("rst0");

        // Boot then free-running steps.
        for (int i = 0; i < 3; i++) tick("free", 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("dir.pc8", pc, 32'h8);
        tick("br40", 1'b0, 1'b1, 32'h40, 1'b0);
        check_eq("dir.pc40", pc, 32'h40);
        check_eq("dir.prev8", prev_pc, 32'h8);
        tick("fl1", 1'b0, 1'b1, 32'h80, 1'b0);   // branch ignored during flush
        tick("fl2", 1'b1, 1'b0, 32'h0, 1'b0);    // stall does not extend flush
        check_eq("dir.flush_done", {31'b0, flush}, 32'h0);
        tick("step44", 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("dir.pc44", pc, 32'h44);

        // Stall holds PC.
        for (int i = 0; i < 3; i++) tick("stall", 1'b1, 1'b0, 32'h0, 1'b0);
        tick("unstall", 1'b0, 1'b0, 32'h0, 1'b0);

        // Wraparound at the top of the address space.
        tick("brtop", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick("fltop1", 1'b0, 1'b0, 32'h0, 1'b0);
        tick("fltop2", 1'b0, 1'b0, 32'h0, 1'b0);
        tick("wrap", 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("dir.wrap0", pc, 32'h0);

        // Reset in the middle of a flush.
        tick("brmid", 1'b0, 1'b1, 32'h100, 1'b0);
        do_reset("rstflush");

        // Simultaneous finish/branch/stall halts; then everything stays frozen.
        for (int i = 0; i < 3; i++) tick("pre", 1'b0, 1'b0, 32'h0, 1'b0);
        tick("fin", 1'b1, 1'b1, 32'h200, 1'b1);
        check_eq("dir.halted", {31'b0, halted}, 32'h1);
        frozen_cc = m_cc;
        for (int i = 0; i < 10; i++)
            tick("hold", 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
        check_eq("dir.cc_frozen", cycle_count, frozen_cc);

        // Branch to a non-word-aligned target.
        do_reset("rstmis");
        for (int i = 0; i < 2; i++) tick("pre2", 1'b0, 1'b0, 32'h0, 1'b0);
        tick("brmis", 1'b0, 1'b1, 32'h42, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check_eq("dir.mis_halt", {31'b0, misalign}, 32'h1);
        check_eq("dir.mis_pc", pc, 32'h4);
`else
        check_eq("dir.mis_pc", pc, 32'h42);
`endif

        // Random episodes.
        for (int e = 0; e < 8; e++) begin
            do_reset("rstrnd");
            for (int i = 0; i < 300; i++) begin
                logic [31:0] t;
                t = $urandom;
                if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
                tick("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t,
                     $urandom_range(0, 199) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
